reg_bank_arbiter: RTL
=====================

Name: reg_bank_arbiter

Overview:
Shares one bank of NUM_REGS configuration registers between two requesters: the host bus (requester 0) and the I2C protocol core (requester 1). Each requester uses a req/ack handshake. Arbitration is round-robin. The block drives the per-register load strobes and the common ins bus of the external register instances, and returns read data from their outputs. It sits between the host interface, the I2C engine and the controller's config/status register bank.

Parameters:
REGISTER_SIZE, 8, width of each bank register in bits
NUM_REGS, 4, number of registers in the bank (2..16)
ADDR_W, $clog2(NUM_REGS) as localparam, address width

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
h_req  in  1  host request; held high until h_ack
h_we  in  1  host: 1 = write, 0 = read
h_addr  in  ADDR_W  host register index
h_wdata  in  REGISTER_SIZE  host write data
h_ack  out  1  host completion pulse, 1 cycle
h_rdata  out  REGISTER_SIZE  host read data, valid with h_ack
c_req, c_we, c_addr, c_wdata  in  1/1/ADDR_W/REGISTER_SIZE  core request group, same rules as host
c_ack  out  1  core completion pulse
c_rdata  out  REGISTER_SIZE  core read data
reg_load  out  NUM_REGS  one-hot load strobes to the bank registers
reg_ins  out  REGISTER_SIZE  data bus to all bank registers
reg_out  in  NUM_REGS*REGISTER_SIZE  flattened bank outputs; register i is at [i*REGISTER_SIZE +: REGISTER_SIZE]

Behaviour:
- Reset: clock and reset_n as stated; reset is asynchronous, active-low. While reset_n is low: state=IDLE, prio=host, h_ack=c_ack=0, h_rdata=c_rdata=0, reg_load=0, reg_ins=0, latched request cleared.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE. Every transaction takes exactly 3 cycles.
- IDLE:
  - If h_req or c_req is high, select the winner and latch its we/addr/wdata and its id. Go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - Only one requester high -> it wins.
  - Both high -> the requester named by prio wins.
  - After every grant, prio is set to the requester that did not win.
- ACCESS:
  - reg_ins = latched wdata.
  - If the access is a write and addr < NUM_REGS, reg_load[addr]=1 for this cycle only. The bank captures the data at the end of this cycle.
  - If the access is a read, the winner's rdata register captures reg_out[addr] at the end of this cycle. If addr >= NUM_REGS, it captures 0.
- DONE:
  - Winner's ack=1 for one cycle. rdata is valid in this cycle. Go to IDLE.
- Output timing:
  - reg_load is decoded from registered state and latched fields only, with no path from the request inputs.
  - ack is a registered Moore output.
- rdata rules:
  - Each requester's rdata holds its last read value until its next read.
  - Writes do not change rdata.
  - The loser's rdata and ack are untouched.
- Out-of-range address (addr >= NUM_REGS): no load strobe, read returns 0, ack is still given.
- Requester obligations:
  - Keep req, we, addr and wdata stable from assertion through the ack cycle.
  - Drop req in the cycle after ack. If req is still high when the FSM is back in IDLE, it is treated as a new request.
- Fairness: with both requesters permanently high, grants alternate H,C,H,C; one transaction per 3 cycles.
- Reset mid-operation: asynchronous return to IDLE. An ACCESS-cycle write is aborted because reg_load drops immediately. No ack is issued for the aborted transaction, and prio returns to host.
- Reset of the bank registers themselves is outside this block.

Decomposition:
- Shared package (i2c_ctrl_pkg or a defines include):
  - state encodings ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_DONE=2'd2
  - requester ids REQ_HOST=1'b0, REQ_CORE=1'b1
- One natural sub-module: rr_arb2. Combinational 2-way round-robin pick: inputs req[1:0] and prio; outputs grant id and grant_valid. The prio flop stays in reg_bank_arbiter.

Test Plan:
- Reset then host write: h_req, h_we=1, h_addr=2, h_wdata=8'hA5 -> reg_load=4'b0100 for exactly 1 cycle (cycle 2) with reg_ins=8'hA5; h_ack on cycle 3; c_ack stays 0.
- Core read: reg_out reg1=8'h3C, c_req, c_we=0, c_addr=1 -> c_ack at cycle 3 with c_rdata=8'h3C; reg_load stays 0 throughout; h_rdata unchanged.
- Simultaneous requests held high, host writing 8'h11 to addr0, core reading addr0 -> first grant to host (reset prio), second to core; c_rdata=8'h11. Continued both-high requests give grant order H,C,H,C.
- Out-of-range with NUM_REGS=3, host read addr=3 and host write addr=3 -> read gives h_rdata=0 with h_ack; write gives no reg_load bit at any time, h_ack still pulses.
- Reset asserted asynchronously mid-cycle during ACCESS of a write -> reg_load falls immediately with no clock edge; no ack. After release, state is IDLE and the next contention is granted to host.
- Back-to-back host reads of addr 0 then 1 -> h_ack pulses exactly 3 cycles apart; h_rdata updates only on ack cycles.

Source files
------------

// File: rtl/reg_bank_arbiter_pkg.sv
// Shared encodings for the config/status register bank arbiter.
package reg_bank_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_CORE = 1'b1;

endpackage

// File: rtl/reg_bank_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; the priority flop lives in the parent.
module rr_arb2
    import reg_bank_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic       grant_id,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |req;
        grant_id    = REQ_HOST;
        unique case (req)
            2'b01:   grant_id = REQ_HOST;
            2'b10:   grant_id = REQ_CORE;
            2'b11:   grant_id = prio;
            default: grant_id = REQ_HOST;
        endcase
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Arbitrates host and I2C-core access to a shared bank of configuration registers.
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int unsigned REGISTER_SIZE = 8,
    parameter int unsigned NUM_REGS      = 4,
    localparam int unsigned ADDR_W       = $clog2(NUM_REGS)
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              h_req,
    input  logic                              h_we,
    input  logic [ADDR_W-1:0]                 h_addr,
    input  logic [REGISTER_SIZE-1:0]          h_wdata,
    output logic                              h_ack,
    output logic [REGISTER_SIZE-1:0]          h_rdata,
    input  logic                              c_req,
    input  logic                              c_we,
    input  logic [ADDR_W-1:0]                 c_addr,
    input  logic [REGISTER_SIZE-1:0]          c_wdata,
    output logic                              c_ack,
    output logic [REGISTER_SIZE-1:0]          c_rdata,
    output logic [NUM_REGS-1:0]               reg_load,
    output logic [REGISTER_SIZE-1:0]          reg_ins,
    input  logic [NUM_REGS*REGISTER_SIZE-1:0] reg_out
);

    logic [1:0]               state_q;
    logic                     prio_q;
    logic                     id_q;
    logic                     we_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [REGISTER_SIZE-1:0] wdata_q;
    logic                     grant_id;
    logic                     grant_valid;
    logic [REGISTER_SIZE-1:0] rd_word;

    rr_arb2 u_arb (
        .req         ({c_req, h_req}),
        .prio        (prio_q),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // Out-of-range addresses match no index, so they read as zero and never strobe.
    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                rd_word = reg_out[i*REGISTER_SIZE +: REGISTER_SIZE];
            end
        end
    end

    // Strobes come only from registered state so a reset drops them without a clock edge.
    always_comb begin
        reg_load = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_load[i] = (state_q == ST_ACCESS) && we_q && (addr_q == ADDR_W'(i));
        end
        reg_ins = (state_q == ST_ACCESS) ? wdata_q : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            prio_q  <= REQ_HOST;
            id_q    <= REQ_HOST;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            h_ack   <= 1'b0;
            c_ack   <= 1'b0;
            h_rdata <= '0;
            c_rdata <= '0;
        end else begin
            h_ack <= 1'b0;
            c_ack <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        state_q <= ST_ACCESS;
                        id_q    <= grant_id;
                        prio_q  <= ~grant_id;
                        we_q    <= (grant_id == REQ_CORE) ? c_we    : h_we;
                        addr_q  <= (grant_id == REQ_CORE) ? c_addr  : h_addr;
                        wdata_q <= (grant_id == REQ_CORE) ? c_wdata : h_wdata;
                    end
                end
                ST_ACCESS: begin
                    state_q <= ST_DONE;
                    h_ack   <= (id_q == REQ_HOST);
                    c_ack   <= (id_q == REQ_CORE);
                    if (!we_q) begin
                        if (id_q == REQ_HOST) begin
                            h_rdata <= rd_word;
                        end else begin
                            c_rdata <= rd_word;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
